mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 2, extra memory cycles per access beyond the first; legal range 0..15.
REQ-002 Parameter ADDR_W, default `ADDRESS_INDEX_LIMIT+1 (26), address width.
REQ-003 Parameter DATA_W, default `DATA_INDEX_LIMIT+1 (32), data width.
REQ-004 CLK  in  1  system clock, all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 CPU_ADDR  in  ADDR_W  processor-side address.
REQ-007 CPU_DATA_W  in  DATA_W  processor write data.
REQ-008 CPU_READ  in  1  processor read request, level.
REQ-009 CPU_WRITE  in  1  processor write request, level.
REQ-010 CPU_DATA_R  out  DATA_W  read data returned to processor.
REQ-011 CPU_READY  out  1  one-cycle completion pulse.
REQ-012 CPU_ERR  out  1  one-cycle illegal-request pulse.
REQ-013 MEM_ADDR  out  ADDR_W  address to memory model.
REQ-014 MEM_DATA_OUT  out  DATA_W  write data to memory.
REQ-015 MEM_DATA_IN  in  DATA_W  read data from memory.
REQ-016 MEM_READ  out  1  memory read strobe.
REQ-017 MEM_WRITE  out  1  memory write strobe.

Function
REQ-018 FSM states IDLE, ACCESS, DONE, ERROR; registered outputs only.
REQ-019 IDLE: CPU_READ xor CPU_WRITE high -> latch CPU_ADDR, CPU_DATA_W and direction, load wait counter with WAIT_STATES, go ACCESS next cycle.
REQ-020 IDLE: CPU_READ and CPU_WRITE both high -> no memory access, go ERROR; ERROR asserts CPU_ERR for one cycle, returns to IDLE.
REQ-021 ACCESS: MEM_ADDR/MEM_DATA_OUT driven from latched values; exactly one of MEM_READ/MEM_WRITE high for WAIT_STATES+1 consecutive cycles.
REQ-022 ACCESS: counter decrements each cycle; at zero, a read captures MEM_DATA_IN into CPU_DATA_R in that same cycle; go DONE.
REQ-023 DONE: strobes low, CPU_READY high one cycle, return to IDLE.
REQ-024 Latency request-sample to CPU_READY = WAIT_STATES+3 cycles (WAIT_STATES=2 -> 5).
REQ-025 CPU requests are ignored outside IDLE; a request held through DONE is re-accepted in the following IDLE cycle (back-to-back throughput = one access per WAIT_STATES+3 cycles).
REQ-026 Request deasserted mid-access: access completes, CPU_READY still pulses.
REQ-027 CPU_DATA_R holds last read value until the next read completes; writes never alter it.
REQ-028 MEM_READ and MEM_WRITE never simultaneously high.
REQ-029 Address not incremented or wrapped; all-ones address (26'h3FFFFFF) passed unchanged.

Reset
REQ-030 RST high at a clock edge: state IDLE, counter 0, CPU_DATA_R 0, CPU_READY 0, CPU_ERR 0, MEM_READ 0, MEM_WRITE 0, MEM_ADDR 0, MEM_DATA_OUT 0.
REQ-031 RST mid-access aborts immediately; no CPU_READY for the aborted access; strobes low the cycle after the reset edge.

Structure
REQ-032 State encoding and WAIT_STATES range constants live in the shared project definition file alongside address/data index limits.
REQ-033 One sub-module, wait_counter (loadable down-counter with zero flag), is instantiated once.

Verification
REQ-034 Read 26'h03FFFFF0 with memory holding 32'hDEADBEEF, WAIT_STATES=2 -> MEM_READ high 3 cycles, CPU_READY at cycle 5, CPU_DATA_R=32'hDEADBEEF.
REQ-035 Write 32'h00000005 to 26'h01000000 -> MEM_WRITE high 3 cycles with correct address/data; CPU_DATA_R unchanged.
REQ-036 CPU_READ and CPU_WRITE both high -> CPU_ERR one pulse, no strobes, no CPU_READY.
REQ-037 RST asserted during second ACCESS cycle -> strobes low next cycle, no CPU_READY, all outputs 0.
REQ-038 WAIT_STATES=0, back-to-back held reads -> strobe 1 cycle each, CPU_READY every 3 cycles.
REQ-039 Request dropped after acceptance -> access completes, CPU_READY pulses once.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared project definitions for the memory access controller.
// Holds the address/data index limits, the wait-state range, the wait
// counter width and the controller state encoding.
package mem_access_ctrl_pkg;

  localparam int unsigned ADDRESS_INDEX_LIMIT = 25;
  localparam int unsigned DATA_INDEX_LIMIT    = 31;

  localparam int unsigned WAIT_STATES_MIN = 0;
  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned WAIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10,
    ERROR  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// wait_counter: loadable down-counter with zero flag.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears count
//   load     - load load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement by one; saturates at zero
//   zero     - high while count is zero
module wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding CPU-to-memory access sequencer.
// A read or write request sampled in IDLE is latched and presented to
// memory for WAIT_STATES+1 cycles, then CPU_READY pulses for one cycle.
// A simultaneous read and write request yields a one-cycle CPU_ERR pulse.
// Ports:
//   CLK, RST                 - clock, synchronous active-high reset
//   CPU_ADDR, CPU_DATA_W     - processor address / write data
//   CPU_READ, CPU_WRITE      - processor request levels
//   CPU_DATA_R               - last read data
//   CPU_READY, CPU_ERR       - completion / illegal-request pulses
//   MEM_ADDR, MEM_DATA_OUT   - memory address / write data
//   MEM_DATA_IN              - memory read data
//   MEM_READ, MEM_WRITE      - memory strobes
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = ADDRESS_INDEX_LIMIT + 1,
  parameter int unsigned DATA_W      = DATA_INDEX_LIMIT + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DATA_W,
  input  logic              CPU_READ,
  input  logic              CPU_WRITE,
  output logic [DATA_W-1:0] CPU_DATA_R,
  output logic              CPU_READY,
  output logic              CPU_ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA_OUT,
  input  logic [DATA_W-1:0] MEM_DATA_IN,
  output logic              MEM_READ,
  output logic              MEM_WRITE
);

  localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

  state_t state;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (state == IDLE) begin
      cnt_load = CPU_READ ^ CPU_WRITE;
    end
    if (state == ACCESS) begin
      cnt_dec = !cnt_zero;
    end
  end

  wait_counter #(
    .W(WAIT_CNT_W)
  ) u_wait_counter (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (WS_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Outputs are registered on the state transition, so the strobes are high
  // exactly during ACCESS, CPU_READY during DONE and CPU_ERR during ERROR.
  // The latched direction is carried by MEM_READ/MEM_WRITE themselves.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      CPU_DATA_R   <= '0;
      CPU_READY    <= 1'b0;
      CPU_ERR      <= 1'b0;
      MEM_ADDR     <= '0;
      MEM_DATA_OUT <= '0;
      MEM_READ     <= 1'b0;
      MEM_WRITE    <= 1'b0;
    end else begin
      CPU_READY <= 1'b0;
      CPU_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (CPU_READ && CPU_WRITE) begin
            state   <= ERROR;
            CPU_ERR <= 1'b1;
          end else if (CPU_READ || CPU_WRITE) begin
            state        <= ACCESS;
            MEM_ADDR     <= CPU_ADDR;
            MEM_DATA_OUT <= CPU_DATA_W;
            MEM_READ     <= CPU_READ;
            MEM_WRITE    <= CPU_WRITE;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            if (MEM_READ) begin
              CPU_DATA_R <= MEM_DATA_IN;
            end
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            CPU_READY <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl: one instance with WAIT_STATES=2
// and one with WAIT_STATES=0 for back-to-back throughput.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [25:0] cpu_addr = '0;
  logic [31:0] cpu_data_w = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_data_r;
  logic        cpu_ready;
  logic        cpu_err;
  logic [25:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_word = '0;

  logic [25:0] z_addr = '0;
  logic [31:0] z_data_w = '0;
  logic        z_read = 1'b0;
  logic        z_write = 1'b0;
  logic [31:0] z_data_r;
  logic        z_ready;
  logic        z_err;
  logic [25:0] z_mem_addr;
  logic [31:0] z_mem_data_out;
  logic [31:0] z_mem_data_in;
  logic        z_mem_read;
  logic        z_mem_write;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // Memory returns the stored word only while it is being read.
  assign mem_data_in   = mem_read   ? mem_word     : 32'h0BAD_0BAD;
  assign z_mem_data_in = z_mem_read ? 32'hCAFEF00D : 32'h0BAD_0BAD;

  mem_access_ctrl #(.WAIT_STATES(2)) dut (
    .CLK(clk), .RST(rst),
    .CPU_ADDR(cpu_addr), .CPU_DATA_W(cpu_data_w),
    .CPU_READ(cpu_read), .CPU_WRITE(cpu_write),
    .CPU_DATA_R(cpu_data_r), .CPU_READY(cpu_ready), .CPU_ERR(cpu_err),
    .MEM_ADDR(mem_addr), .MEM_DATA_OUT(mem_data_out), .MEM_DATA_IN(mem_data_in),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write)
  );

  mem_access_ctrl #(.WAIT_STATES(0)) dut_ws0 (
    .CLK(clk), .RST(rst),
    .CPU_ADDR(z_addr), .CPU_DATA_W(z_data_w),
    .CPU_READ(z_read), .CPU_WRITE(z_write),
    .CPU_DATA_R(z_data_r), .CPU_READY(z_ready), .CPU_ERR(z_err),
    .MEM_ADDR(z_mem_addr), .MEM_DATA_OUT(z_mem_data_out), .MEM_DATA_IN(z_mem_data_in),
    .MEM_READ(z_mem_read), .MEM_WRITE(z_mem_write)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs ncyc clock edges, summarising the selected instance's outputs.
  // Requests are released after edge drop_at (0 = hold them).
  task automatic observe(input bit sel, input int unsigned ncyc, input int unsigned drop_at,
                         input logic [25:0] exp_addr, input logic [31:0] exp_wdata,
                         output int unsigned rd, output int unsigned wr,
                         output int unsigned rdy, output int unsigned err,
                         output int unsigned first_rdy, output int unsigned last_rdy,
                         output int unsigned bad);
    logic        r, w, y, e;
    logic [25:0] a;
    logic [31:0] d;
    rd = 0; wr = 0; rdy = 0; err = 0; first_rdy = 0; last_rdy = 0; bad = 0;
    for (int unsigned i = 1; i <= ncyc; i++) begin
      tick();
      if (i == drop_at) begin
        if (sel) begin z_read = 1'b0; z_write = 1'b0; end
        else begin cpu_read = 1'b0; cpu_write = 1'b0; end
      end
      r = sel ? z_mem_read     : mem_read;
      w = sel ? z_mem_write    : mem_write;
      y = sel ? z_ready        : cpu_ready;
      e = sel ? z_err          : cpu_err;
      a = sel ? z_mem_addr     : mem_addr;
      d = sel ? z_mem_data_out : mem_data_out;
      if (r) rd++;
      if (w) wr++;
      if (r && w) bad++;
      if ((r || w) && (a != exp_addr)) bad++;
      if (w && (d != exp_wdata)) bad++;
      if (e) err++;
      if (y) begin
        rdy++;
        if (first_rdy == 0) first_rdy = i;
        last_rdy = i;
      end
    end
  endtask

  initial begin
    int unsigned rd, wr, rdy, err, first_rdy, last_rdy, bad;

    // Reset state
    tick();
    tick();
    check("rst_data_r",   cpu_data_r, 0);
    check("rst_ready",    cpu_ready, 0);
    check("rst_err",      cpu_err, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_wr",   mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_dout", mem_data_out, 0);
    rst = 1'b0;
    tick();

    // Read 0x3FFFFF0, WS=2: 3 strobe cycles, ready in 5th cycle counting the
    // request cycle, i.e. 4 edges after the request is driven.
    mem_word = 32'hDEADBEEF;
    cpu_addr = 26'h3FFFFF0;
    cpu_read = 1'b1;
    observe(1'b0, 8, 1, 26'h3FFFFF0, 32'h0, rd, wr, rdy, err, first_rdy, last_rdy, bad);
    check("rd_strobes",  rd, 3);
    check("rd_no_write", wr, 0);
    check("rd_ready",    rdy, 1);
    check("rd_latency",  first_rdy, 4);
    check("rd_bad",      bad, 0);
    check("rd_data",     cpu_data_r, 32'hDEADBEEF);

    // Write 5 to 0x1000000; read data must be untouched.
    mem_word   = 32'h11111111;
    cpu_addr   = 26'h1000000;
    cpu_data_w = 32'h00000005;
    cpu_write  = 1'b1;
    observe(1'b0, 8, 1, 26'h1000000, 32'h00000005, rd, wr, rdy, err, first_rdy, last_rdy, bad);
    check("wr_strobes", wr, 3);
    check("wr_no_read", rd, 0);
    check("wr_ready",   rdy, 1);
    check("wr_latency", first_rdy, 4);
    check("wr_bad",     bad, 0);
    check("wr_data_r",  cpu_data_r, 32'hDEADBEEF);

    // Simultaneous read and write: single error pulse, no access.
    cpu_read  = 1'b1;
    cpu_write = 1'b1;
    observe(1'b0, 6, 1, 26'h0, 32'h0, rd, wr, rdy, err, first_rdy, last_rdy, bad);
    check("err_pulses", err, 1);
    check("err_rd",     rd, 0);
    check("err_wr",     wr, 0);
    check("err_ready",  rdy, 0);

    // All-ones address, then reset during the second ACCESS cycle.
    mem_word = 32'h12345678;
    cpu_addr = 26'h3FFFFFF;
    cpu_read = 1'b1;
    tick();
    cpu_read = 1'b0;
    check("ones_strobe", mem_read, 1);
    check("ones_addr",   mem_addr, 26'h3FFFFFF);
    tick();
    check("abort_in_access", mem_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_mem_read", mem_read, 0);
    check("abort_mem_wr",   mem_write, 0);
    check("abort_ready",    cpu_ready, 0);
    check("abort_data_r",   cpu_data_r, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_dout", mem_data_out, 0);
    observe(1'b0, 6, 0, 26'h0, 32'h0, rd, wr, rdy, err, first_rdy, last_rdy, bad);
    check("abort_no_ready",  rdy, 0);
    check("abort_no_strobe", rd + wr, 0);

    // WS=0, read held: accepted at edges 1,4,7, ready after edges 2,5,8.
    z_addr = 26'h0000123;
    z_read = 1'b1;
    observe(1'b1, 9, 0, 26'h0000123, 32'h0, rd, wr, rdy, err, first_rdy, last_rdy, bad);
    z_read = 1'b0;
    check("ws0_strobes",   rd, 3);
    check("ws0_ready",     rdy, 3);
    check("ws0_first_rdy", first_rdy, 2);
    check("ws0_last_rdy",  last_rdy, 8);
    check("ws0_bad",       bad, 0);
    check("ws0_data",      z_data_r, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
